// File: rtl/servo_scan_scheduler.sv
// Steps the PWM decoder through 0/+90/-90 degrees and back to 0, settling and taking one
// distance measurement per position. All outputs are registered; stop aborts from any active state.
module servo_scan_scheduler #(
    parameter int SETTLE_CYCLES  = 50_000_000,
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int MEAS_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              meas_valid,
    input  logic [MEAS_W-1:0] meas_dist,
    output logic [2:0]        orden,
    output logic              meas_start,
    output logic [MEAS_W-1:0] dist_0,
    output logic [MEAS_W-1:0] dist_90,
    output logic [MEAS_W-1:0] dist_m90,
    output logic [2:0]        timeout_flags,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int MAX_C = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(MAX_C);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        TRIG   = 3'd2,
        WAIT   = 3'd3,
        PARK   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        pos_q, pos_d;
    logic [2:0]        orden_q, orden_d;
    logic              meas_start_q, meas_start_d;
    logic [MEAS_W-1:0] dist_0_q, dist_0_d;
    logic [MEAS_W-1:0] dist_90_q, dist_90_d;
    logic [MEAS_W-1:0] dist_m90_q, dist_m90_d;
    logic [2:0]        tflags_q, tflags_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [MEAS_W-1:0] result;

    // Registered outputs are computed from the next state so they change together with it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        pos_d        = pos_q;
        orden_d      = orden_q;
        meas_start_d = 1'b0;
        dist_0_d     = dist_0_q;
        dist_90_d    = dist_90_q;
        dist_m90_d   = dist_m90_q;
        tflags_d     = tflags_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        result       = meas_valid ? meas_dist : {MEAS_W{1'b1}};

        if (state_q == IDLE) begin
            cnt_d   = '0;
            orden_d = 3'b000;
            busy_d  = 1'b0;
            if (start && !stop) begin
                tflags_d = 3'b000;
                pos_d    = 2'd0;
                orden_d  = 3'b100;
                busy_d   = 1'b1;
                state_d  = SETTLE;
            end
        end else if (stop) begin
            state_d   = IDLE;
            cnt_d     = '0;
            pos_d     = 2'd0;
            orden_d   = 3'b000;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d      = TRIG;
                        cnt_d        = '0;
                        meas_start_d = 1'b1;
                    end
                end
                TRIG: begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
                WAIT: begin
                    if (meas_valid || cnt_q == TIMEOUT_LAST) begin
                        case (pos_q)
                            2'd0:    dist_0_d   = result;
                            2'd1:    dist_90_d  = result;
                            default: dist_m90_d = result;
                        endcase
                        if (!meas_valid) begin
                            case (pos_q)
                                2'd0:    tflags_d[0] = 1'b1;
                                2'd1:    tflags_d[1] = 1'b1;
                                default: tflags_d[2] = 1'b1;
                            endcase
                        end
                        cnt_d = '0;
                        if (pos_q != 2'd2) begin
                            pos_d   = pos_q + 2'd1;
                            orden_d = {1'b1, pos_q + 2'd1};
                            state_d = SETTLE;
                        end else begin
                            orden_d = 3'b100;
                            state_d = PARK;
                        end
                    end
                end
                PARK: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        orden_d = 3'b000;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    orden_d = 3'b000;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pos_q        <= 2'd0;
            orden_q      <= 3'b000;
            meas_start_q <= 1'b0;
            dist_0_q     <= '0;
            dist_90_q    <= '0;
            dist_m90_q   <= '0;
            tflags_q     <= 3'b000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            orden_q      <= orden_d;
            meas_start_q <= meas_start_d;
            dist_0_q     <= dist_0_d;
            dist_90_q    <= dist_90_d;
            dist_m90_q   <= dist_m90_d;
            tflags_q     <= tflags_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign orden         = orden_q;
    assign meas_start    = meas_start_q;
    assign dist_0        = dist_0_q;
    assign dist_90       = dist_90_q;
    assign dist_m90      = dist_m90_q;
    assign timeout_flags = tflags_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;

endmodule

// File: tb/tb_servo_scan_scheduler.sv
// Directed bench for servo_scan_scheduler with SETTLE=4, TIMEOUT=8.
// Cycle n means the interval just after clock edge n; start is driven in cycle 0.
module tb_servo_scan_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        meas_valid;
    logic [15:0] meas_dist;
    logic [2:0]  orden;
    logic        meas_start;
    logic [15:0] dist_0;
    logic [15:0] dist_90;
    logic [15:0] dist_m90;
    logic [2:0]  timeout_flags;
    logic        busy;
    logic        done;
    logic        aborted;

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cyc;
    int          ab_cyc;
    int          nchg;
    logic [23:0] ms_pack;
    logic [14:0] seq;
    logic        busy1;

    always #5 clk = ~clk;

    servo_scan_scheduler #(
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(8),
        .MEAS_W        (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .meas_valid   (meas_valid),
        .meas_dist    (meas_dist),
        .orden        (orden),
        .meas_start   (meas_start),
        .dist_0       (dist_0),
        .dist_90      (dist_90),
        .dist_m90     (dist_m90),
        .timeout_flags(timeout_flags),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reactive measurement unit: answers on the cycle after meas_start when resp[pos] is set.
    task automatic run_scan(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                            input logic [2:0] resp, input bit stray, input int stop_cyc,
                            input bit stop_valid, input int rst_cyc);
        logic [15:0] dv [3];
        logic [2:0]  prev_or;
        bit          prev_ms;
        int          ms_n;
        dv[0] = d0;
        dv[1] = d1;
        dv[2] = d2;
        step;
        step;
        start    = 1'b1;
        ms_pack  = '0;
        seq      = '0;
        nchg     = 0;
        done_cyc = 0;
        ab_cyc   = 0;
        busy1    = 1'b0;
        prev_ms  = 1'b0;
        ms_n     = 0;
        prev_or  = orden;
        for (int c = 1; c <= 60; c++) begin
            step;
            start      = 1'b0;
            stop       = 1'b0;
            meas_valid = 1'b0;
            meas_dist  = '0;
            if (c == 1) busy1 = busy;
            if (meas_start) begin
                ms_pack = {ms_pack[15:0], 8'(c)};
                ms_n++;
            end
            if (orden !== prev_or) begin
                seq     = {seq[11:0], orden};
                nchg++;
                prev_or = orden;
            end
            if (done) done_cyc = c;
            if (aborted) ab_cyc = c;
            if (done || aborted || (rst_cyc != 0 && c == rst_cyc + 1)) break;
            if (prev_ms && ms_n >= 1 && resp[ms_n-1]) begin
                meas_valid = 1'b1;
                meas_dist  = dv[ms_n-1];
            end
            if (prev_ms && stray) start = 1'b1;
            if (stray && (c == 2 || c == 8)) begin
                meas_valid = 1'b1;
                meas_dist  = 16'd999;
            end
            if (c == stop_cyc) begin
                stop = 1'b1;
                if (stop_valid) begin
                    meas_valid = 1'b1;
                    meas_dist  = 16'h004D;
                end
            end
            if (c == rst_cyc) reset = 1'b0;
            prev_ms = meas_start;
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        meas_valid = 1'b0;
        meas_dist  = '0;
        step;
        step;
        chk("rst_orden", 32'(orden), 32'h0);
        chk("rst_outs", {busy, done, aborted, meas_start, timeout_flags}, 32'h0);
        chk("rst_dists", {dist_0, dist_90 | dist_m90}, 32'h0);
        reset = 1'b1;
        step;

        // start together with stop in IDLE: nothing happens
        start = 1'b1;
        stop  = 1'b1;
        step;
        start = 1'b0;
        stop  = 1'b0;
        step;
        chk("idle_ss_outs", {busy, aborted, done, orden}, 32'h0);

        // nominal scan
        run_scan(16'd100, 16'd200, 16'd300, 3'b111, 1'b0, 0, 1'b0, 0);
        chk("nom_busy1", 32'(busy1), 32'h1);
        chk("nom_ms_cycles", 32'(ms_pack), 32'h00050B11);
        chk("nom_orden_seq", 32'(seq), 32'(15'b100_101_110_100_000));
        chk("nom_orden_chg", nchg, 5);
        chk("nom_done_cyc", done_cyc, 23);
        chk("nom_busy_done", 32'(busy), 32'h0);
        chk("nom_d0", 32'(dist_0), 32'd100);
        chk("nom_d90", 32'(dist_90), 32'd200);
        chk("nom_dm90", 32'(dist_m90), 32'd300);
        chk("nom_tflags", 32'(timeout_flags), 32'h0);
        step;
        chk("nom_done_pulse", 32'(done), 32'h0);

        // no answer at +90: timeout path
        run_scan(16'h0111, 16'h0222, 16'h0333, 3'b101, 1'b0, 0, 1'b0, 0);
        chk("to_done_cyc", done_cyc, 30);
        chk("to_ms_cycles", 32'(ms_pack), 32'h00050B18);
        chk("to_d0", 32'(dist_0), 32'h0111);
        chk("to_d90", 32'(dist_90), 32'hFFFF);
        chk("to_dm90", 32'(dist_m90), 32'h0333);
        chk("to_tflags", 32'(timeout_flags), 32'b010);

        // stop during second SETTLE
        run_scan(16'd11, 16'd22, 16'd33, 3'b111, 1'b0, 8, 1'b0, 0);
        chk("stp_ab_cyc", ab_cyc, 9);
        chk("stp_no_done", done_cyc, 0);
        chk("stp_outs", {busy, orden}, 32'h0);
        chk("stp_d0", 32'(dist_0), 32'd11);
        chk("stp_d90", 32'(dist_90), 32'hFFFF);
        chk("stp_dm90", 32'(dist_m90), 32'h0333);
        chk("stp_tflags", 32'(timeout_flags), 32'h0);
        step;
        chk("stp_ab_pulse", {aborted, done}, 32'h0);

        // stray start in WAIT and stray meas_valid in SETTLE
        run_scan(16'd40, 16'd50, 16'd60, 3'b111, 1'b1, 0, 1'b0, 0);
        chk("str_ms_cycles", 32'(ms_pack), 32'h00050B11);
        chk("str_done_cyc", done_cyc, 23);
        chk("str_dists", {dist_0, dist_90}, {16'd40, 16'd50});
        chk("str_dm90", 32'(dist_m90), 32'd60);

        // stop and meas_valid in the same WAIT cycle
        run_scan(16'd70, 16'd80, 16'd90, 3'b111, 1'b0, 12, 1'b1, 0);
        chk("sv_ab_cyc", ab_cyc, 13);
        chk("sv_no_done", done_cyc, 0);
        chk("sv_d0", 32'(dist_0), 32'd70);
        chk("sv_d90", 32'(dist_90), 32'd50);
        chk("sv_dm90", 32'(dist_m90), 32'd60);

        // reset during PARK
        run_scan(16'd1, 16'd2, 16'd3, 3'b111, 1'b0, 0, 1'b0, 20);
        chk("mr_no_done", done_cyc + ab_cyc, 0);
        chk("mr_orden", 32'(orden), 32'h0);
        chk("mr_outs", {busy, done, aborted, meas_start, timeout_flags}, 32'h0);
        chk("mr_dists", {dist_0, dist_90 | dist_m90}, 32'h0);
        reset = 1'b1;
        step;
        step;
        chk("mr_idle", {busy, done, aborted, orden}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/servo_scan_scheduler.md
# servo_scan_scheduler

Sequences the servo PWM decoder through a three-position scan (0°, +90°, −90°) and returns it to 0°. At each position it waits a settle time, triggers one distance measurement and stores the result. It drives the decoder's 3-bit `orden` command: bit 2 enables the PWM, and bits 1:0 select the angle (00 = 0°, 01 = 90°, 10 = −90°, 11 = error, never issued). It sits between the control processor interface and the PWM decoder and measurement unit.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 50_000_000: clock cycles held at each position before triggering; legal range ≥ 1.
- `TIMEOUT_CYCLES`, default 2_500_000: cycles to wait for `meas_valid` before giving up; legal range ≥ 1.
- `MEAS_W`, default 16: width of distance values.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-low.
- `start`, input, 1: begin a scan; sampled only in IDLE.
- `stop`, input, 1: abort the scan; sampled in every state.
- `meas_valid`, input, 1: measurement unit result strobe.
- `meas_dist`, input, MEAS_W: distance, qualified by `meas_valid`.
- `orden`, output, 3: command to the PWM decoder.
- `meas_start`, output, 1: one-cycle trigger to the measurement unit.
- `dist_0`, `dist_90`, `dist_m90`, output, MEAS_W each: stored results.
- `timeout_flags`, output, 3: per-position timeout. Bit 0 = 0°, bit 1 = 90°, bit 2 = −90°.
- `busy`, output, 1: scan in progress.
- `done`, output, 1: one-cycle pulse on normal completion.
- `aborted`, output, 1: one-cycle pulse on stop.

## Operation
- All outputs are registered.
- Reset values: `orden`=000, `meas_start`=0, all `dist_*`=0, `timeout_flags`=000, `busy`=0, `done`=0, `aborted`=0. State is IDLE and both counters are 0.
- States: IDLE, SETTLE, TRIG, WAIT, PARK, DONE.
- IDLE
  - `orden`=000, `busy`=0.
  - On `start`=1 (and `stop`=0): clear `timeout_flags`, set position index p=0, `orden`={1,00}, `busy`=1, go to SETTLE.
- SETTLE
  - Hold `orden`={1,pos(p)} with pos = 00, 01, 10 for p = 0, 1, 2.
  - After exactly SETTLE_CYCLES cycles in SETTLE, go to TRIG.
- TRIG: `meas_start`=1 for this one cycle only, then go to WAIT.
- WAIT
  - If `meas_valid`=1: capture `meas_dist` into the register for p.
  - If TIMEOUT_CYCLES cycles elapse with no valid: store all-ones and set `timeout_flags[p]`.
  - Then, if p<2: p←p+1, go to SETTLE. If p=2: `orden`←{1,00}, go to PARK.
- PARK: hold `orden`={1,00} for SETTLE_CYCLES cycles, then go to DONE.
- DONE: `orden`=000, `done`=1 for this one cycle, `busy`=0, return to IDLE.
- `meas_valid` outside WAIT is ignored, and no register changes.
- `start` outside IDLE is ignored.
- `stop`=1 in any non-IDLE state:
  - Next cycle: IDLE, `orden`=000, `busy`=0, `aborted`=1 for one cycle, `meas_start`=0.
  - Counters clear.
  - Results already stored in this scan are kept; positions not yet reached keep their previous values.
- `stop` and `meas_valid` in the same WAIT cycle: stop wins and no capture occurs.
- `stop` and `start` in IDLE: no scan starts, and `aborted` does not pulse.
- Counters are sized to `$clog2(max(SETTLE_CYCLES,TIMEOUT_CYCLES)+1)` bits. They reset to 0 on every state entry and never wrap.
- `reset`=0 mid-scan: at the next edge all outputs take their reset values. No `done` or `aborted` pulse.

## Timing
- `start` is sampled at edge 0. `orden`={1,00} and `busy`=1 are visible after edge 1.
- Per position: SETTLE_CYCLES cycles settle, 1 cycle TRIG, then 1 to TIMEOUT_CYCLES cycles WAIT.
- The earliest capture is on the first WAIT cycle, which is TRIG+1.
- Timeout capture happens on WAIT cycle TIMEOUT_CYCLES. A `meas_valid` in that same cycle counts as valid.
- Minimum scan: `done` is high in cycle 3·(SETTLE_CYCLES+2)+SETTLE_CYCLES+1 after the `start` edge.
- `orden` changes only at state transitions and is glitch-free (registered).

## Test plan
- SETTLE=4, TIMEOUT=8. `start` at edge 0. `meas_valid` with dist 100/200/300 on each first WAIT cycle.
  - `meas_start` pulses in cycles 5, 11, 17.
  - `orden` sequence 100→101→110→100→000.
  - `done` in cycle 23.
  - `dist_0`=100, `dist_90`=200, `dist_m90`=300, `timeout_flags`=000.
- Same setup, but `meas_valid` is never asserted at 90°: `dist_90`=16'hFFFF, `timeout_flags`=010, and `done` arrives 7 cycles later than the minimum.
- `stop` during the second SETTLE:
  - Next cycle `orden`=000, `aborted`=1, `busy`=0.
  - `dist_0` is updated; `dist_90` and `dist_m90` are unchanged.
  - No `done` pulse.
- `start` pulsed during WAIT, and `meas_valid` pulsed during SETTLE: no effect on state, results or `meas_start` count.
- `stop` and `meas_valid` in the same WAIT cycle: no capture, abort is taken.
- `reset`=0 asserted in the middle of PARK: after the next edge all outputs equal their reset values. Releasing `reset` leaves the block in IDLE with `orden`=000.
